vl_strip_ctrl: RTL and testbench

//  Strip-mining sequencer for the vector unit. Accepts one vector-op config (SEW, LMUL, total AVL).

---
 rtl/vec_cfg_pkg.sv | 47 ++++
 rtl/vl_strip_ctrl_if.sv | 32 +++
 rtl/vlmax_calc.sv | 29 ++
 rtl/vl_strip_ctrl.sv | 147 ++++++++++++++
 tb/tb_vl_strip_ctrl.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vec_cfg_pkg.sv
// Shared vector-config definitions: geometry, legal SEW/LMUL checks and the
// strip sequencer state encoding.
package vec_cfg_pkg;

    localparam int VLEN  = 128;
    localparam int AVL_W = 9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    function automatic logic sew_legal(input logic [7:0] sew);
        logic ok;
        case (sew)
            8'd8, 8'd16, 8'd32, 8'd64, 8'd128: ok = 1'b1;
            default:                           ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic lmul_legal(input logic [4:0] lmul);
        logic ok;
        case (lmul)
            5'd1, 5'd2, 5'd4, 5'd8, 5'd16: ok = 1'b1;
            default:                       ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Illegal widths map to 3 so the shifter stays bounded; legality masks the result.
    function automatic logic [2:0] sew_log2(input logic [7:0] sew);
        logic [2:0] lg;
        case (sew)
            8'd8:    lg = 3'd3;
            8'd16:   lg = 3'd4;
            8'd32:   lg = 3'd5;
            8'd64:   lg = 3'd6;
            8'd128:  lg = 3'd7;
            default: lg = 3'd3;
        endcase
        return lg;
    endfunction

endpackage

// File: rtl/vl_strip_ctrl_if.sv
// Config and strip handshake bundle between vsetvl decode, the strip
// sequencer and the lane issue logic.
interface vl_strip_ctrl_if;

    logic                           cfg_valid;
    logic                           cfg_ready;
    logic [7:0]                     cfg_sew;
    logic [4:0]                     cfg_lmul;
    logic [vec_cfg_pkg::AVL_W-1:0]  cfg_avl;
    logic                           abort;
    logic                           strip_valid;
    logic                           strip_ready;
    logic [vec_cfg_pkg::AVL_W-1:0]  strip_vl;
    logic [vec_cfg_pkg::AVL_W-1:0]  strip_off;
    logic [vec_cfg_pkg::AVL_W-1:0]  strip_idx;
    logic                           strip_last;
    logic                           done;
    logic                           cfg_err;

    modport master (
        output cfg_valid, cfg_sew, cfg_lmul, cfg_avl, abort, strip_ready,
        input  cfg_ready, strip_valid, strip_vl, strip_off, strip_idx,
               strip_last, done, cfg_err
    );

    modport slave (
        input  cfg_valid, cfg_sew, cfg_lmul, cfg_avl, abort, strip_ready,
        output cfg_ready, strip_valid, strip_vl, strip_off, strip_idx,
               strip_last, done, cfg_err
    );

endinterface

// File: rtl/vlmax_calc.sv
// Combinational VLMAX = (VLEN/SEW)*LMUL with a legality flag; VLMAX reads 0
// for illegal SEW/LMUL.
module vlmax_calc
    import vec_cfg_pkg::*;
(
    input  logic [7:0]       i_sew,
    input  logic [4:0]       i_lmul,
    output logic [AVL_W-1:0] o_vlmax,
    output logic             o_legal
);

    logic [2:0]       w_lg;
    logic [AVL_W-1:0] w_elems;
    logic [AVL_W-1:0] w_prod;

    // Largest legal product is 16 elements * LMUL 16 = 256, inside AVL_W bits.
    always_comb begin
        w_lg    = sew_log2(i_sew);
        w_elems = AVL_W'(VLEN >> w_lg);
        w_prod  = w_elems * AVL_W'(i_lmul);
        o_legal = sew_legal(i_sew) & lmul_legal(i_lmul);
        if (o_legal) begin
            o_vlmax = w_prod;
        end else begin
            o_vlmax = {AVL_W{1'b0}};
        end
    end

endmodule

// File: rtl/vl_strip_ctrl.sv
// Strip-mining sequencer: splits one vector op of AVL elements into strips of
// at most VLMAX elements and hands them to the lanes over valid/ready.
module vl_strip_ctrl
    import vec_cfg_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    vl_strip_ctrl_if.slave    bus
);

    state_t           r_state;
    logic [AVL_W-1:0] r_rem;
    logic [AVL_W-1:0] r_off;
    logic [AVL_W-1:0] r_idx;
    logic [AVL_W-1:0] r_vlmax;
    logic [AVL_W-1:0] r_strip_vl;
    logic             r_strip_last;
    logic             r_strip_valid;
    logic             r_done;
    logic             r_cfg_err;
    logic             r_cfg_ready;

    logic [AVL_W-1:0] w_vlmax;
    logic             w_legal;
    logic             w_accept;
    logic             w_hs;
    logic [AVL_W-1:0] w_rem_nxt;
    logic [AVL_W-1:0] w_next_vl;
    logic             w_next_last;
    logic [AVL_W-1:0] w_first_vl;
    logic             w_first_last;

    vlmax_calc u_vlmax (
        .i_sew   (bus.cfg_sew),
        .i_lmul  (bus.cfg_lmul),
        .o_vlmax (w_vlmax),
        .o_legal (w_legal)
    );

    // Strip geometry for the first strip (from cfg) and the one after a handshake.
    always_comb begin
        w_accept  = bus.cfg_valid & r_cfg_ready;
        w_hs      = r_strip_valid & bus.strip_ready;
        w_rem_nxt = r_rem - r_strip_vl;
        if (w_rem_nxt < r_vlmax) begin
            w_next_vl = w_rem_nxt;
        end else begin
            w_next_vl = r_vlmax;
        end
        w_next_last = (w_rem_nxt <= r_vlmax);
        if (bus.cfg_avl < w_vlmax) begin
            w_first_vl = bus.cfg_avl;
        end else begin
            w_first_vl = w_vlmax;
        end
        w_first_last = (bus.cfg_avl <= w_vlmax);
    end

    // Sequencer FSM; strip outputs are precomputed so they are plain flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_rem         <= {AVL_W{1'b0}};
            r_off         <= {AVL_W{1'b0}};
            r_idx         <= {AVL_W{1'b0}};
            r_vlmax       <= {AVL_W{1'b0}};
            r_strip_vl    <= {AVL_W{1'b0}};
            r_strip_last  <= 1'b0;
            r_strip_valid <= 1'b0;
            r_done        <= 1'b0;
            r_cfg_err     <= 1'b0;
            r_cfg_ready   <= 1'b1;
        end else begin
            r_done    <= 1'b0;
            r_cfg_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_vlmax     <= w_vlmax;
                        r_rem       <= bus.cfg_avl;
                        r_off       <= {AVL_W{1'b0}};
                        r_idx       <= {AVL_W{1'b0}};
                        r_cfg_ready <= 1'b0;
                        if (!w_legal) begin
                            r_state   <= ST_ERR;
                            r_cfg_err <= 1'b1;
                        end else if (bus.cfg_avl == {AVL_W{1'b0}}) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state       <= ST_RUN;
                            r_strip_valid <= 1'b1;
                            r_strip_vl    <= w_first_vl;
                            r_strip_last  <= w_first_last;
                        end
                    end else begin
                        r_cfg_ready <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (w_hs) begin
                        r_rem        <= w_rem_nxt;
                        r_off        <= r_off + r_strip_vl;
                        r_idx        <= r_idx + {{(AVL_W-1){1'b0}}, 1'b1};
                        r_strip_vl   <= w_next_vl;
                        r_strip_last <= w_next_last;
                    end
                    // Abort wins over completion: an accepted final strip still gets no done.
                    if (bus.abort) begin
                        r_state       <= ST_IDLE;
                        r_strip_valid <= 1'b0;
                        r_cfg_ready   <= 1'b1;
                    end else if (w_hs && r_strip_last) begin
                        r_state       <= ST_DONE;
                        r_strip_valid <= 1'b0;
                        r_done        <= 1'b1;
                    end else begin
                        r_state <= ST_RUN;
                    end
                end
                ST_DONE: begin
                    r_state     <= ST_IDLE;
                    r_cfg_ready <= 1'b1;
                end
                ST_ERR: begin
                    r_state     <= ST_IDLE;
                    r_cfg_ready <= 1'b1;
                end
                default: begin
                    r_state       <= ST_IDLE;
                    r_strip_valid <= 1'b0;
                    r_cfg_ready   <= 1'b1;
                end
            endcase
        end
    end

    assign bus.cfg_ready   = r_cfg_ready;
    assign bus.strip_valid = r_strip_valid;
    assign bus.strip_vl    = r_strip_vl;
    assign bus.strip_off   = r_off;
    assign bus.strip_idx   = r_idx;
    assign bus.strip_last  = r_strip_last;
    assign bus.done        = r_done;
    assign bus.cfg_err     = r_cfg_err;

endmodule

// File: tb/tb_vl_strip_ctrl.sv
// Scoreboard bench for vl_strip_ctrl: directed configs push expected strips
// and pulses; a negedge monitor pops and compares whatever the DUT presents.
module tb_vl_strip_ctrl;
    import vec_cfg_pkg::*;

    localparam int K_STRIP = 0;
    localparam int K_DONE  = 1;
    localparam int K_ERR   = 2;

    typedef struct {
        int kind;
        int vl;
        int off;
        int idx;
        int last;
    } exp_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    exp_t sb[$];

    vl_strip_ctrl_if bus ();

    vl_strip_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    task automatic push_strip(input int vl, input int off, input int idx, input int last);
        exp_t e;
        e.kind = K_STRIP; e.vl = vl; e.off = off; e.idx = idx; e.last = last;
        sb.push_back(e);
    endtask

    task automatic push_evt(input int kind);
        exp_t e;
        e.kind = kind; e.vl = 0; e.off = 0; e.idx = 0; e.last = 0;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cfg(input int sew, input int lmul, input int avl);
        int ok;
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            if (bus.cfg_ready) begin
                ok = 1;
                break;
            end
            step();
        end
        if (ok == 0) fail_now("cfg_ready_timeout");
        bus.cfg_sew   = 8'(sew);
        bus.cfg_lmul  = 5'(lmul);
        bus.cfg_avl   = 9'(avl);
        bus.cfg_valid = 1'b1;
        step();
        bus.cfg_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int ok;
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            step();
            if (bus.cfg_ready && sb.size() == 0) begin
                ok = 1;
                break;
            end
        end
        if (ok == 0) fail_now("idle_timeout");
    endtask

    task automatic done_latency(input int exp_c);
        int found;
        found = 0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (bus.done) begin
                chk("done_latency", c, exp_c);
                found = 1;
                break;
            end
        end
        if (found == 0) fail_now("done_never_seen");
    endtask

    // Monitor: a stalled strip being aborted is cancelled, so it is not compared.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.strip_valid && !(bus.abort && !bus.strip_ready)) begin
                chk("cfg_ready_low_in_run", int'(bus.cfg_ready), 0);
                if (sb.size() == 0) begin
                    fail_now("unexpected_strip");
                end else if (sb[0].kind != K_STRIP) begin
                    chk("strip_kind", K_STRIP, sb[0].kind);
                end else begin
                    chk("strip_vl",   int'(bus.strip_vl),   sb[0].vl);
                    chk("strip_off",  int'(bus.strip_off),  sb[0].off);
                    chk("strip_idx",  int'(bus.strip_idx),  sb[0].idx);
                    chk("strip_last", int'(bus.strip_last), sb[0].last);
                    if (bus.strip_ready) void'(sb.pop_front());
                end
            end
            if (bus.done) begin
                if (sb.size() == 0) begin
                    fail_now("unexpected_done");
                end else begin
                    chk("done_kind", K_DONE, sb[0].kind);
                    void'(sb.pop_front());
                end
            end
            if (bus.cfg_err) begin
                if (sb.size() == 0) begin
                    fail_now("unexpected_cfg_err");
                end else begin
                    chk("err_kind", K_ERR, sb[0].kind);
                    void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "global timeout");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        bus.cfg_valid   = 1'b0;
        bus.cfg_sew     = 8'd8;
        bus.cfg_lmul    = 5'd1;
        bus.cfg_avl     = 9'd0;
        bus.abort       = 1'b0;
        bus.strip_ready = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_cfg_ready",   int'(bus.cfg_ready),   1);
        chk("rst_strip_valid", int'(bus.strip_valid), 0);
        chk("rst_done",        int'(bus.done),        0);
        chk("rst_cfg_err",     int'(bus.cfg_err),     0);
        chk("rst_strip_vl",    int'(bus.strip_vl),    0);
        chk("rst_strip_off",   int'(bus.strip_off),   0);
        chk("rst_strip_idx",   int'(bus.strip_idx),   0);
        chk("rst_strip_last",  int'(bus.strip_last),  0);
        step();

        // SEW32 LMUL2: vlmax 8, AVL 20 -> 8,8,4.
        bus.strip_ready = 1'b1;
        push_strip(8, 0, 0, 0);
        push_strip(8, 8, 1, 0);
        push_strip(4, 16, 2, 1);
        push_evt(K_DONE);
        send_cfg(32, 2, 20);
        done_latency(4);
        wait_idle();

        // SEW8 LMUL16: vlmax 256, AVL 300 -> 256, 44.
        push_strip(256, 0, 0, 0);
        push_strip(44, 256, 1, 1);
        push_evt(K_DONE);
        send_cfg(8, 16, 300);
        done_latency(3);
        wait_idle();

        // AVL 0: done with no strip, cfg_ready back one cycle later.
        push_evt(K_DONE);
        send_cfg(16, 1, 0);
        @(negedge clk);
        chk("avl0_done",        int'(bus.done),        1);
        chk("avl0_no_strip",    int'(bus.strip_valid), 0);
        chk("avl0_ready_low",   int'(bus.cfg_ready),   0);
        @(negedge clk);
        chk("avl0_done_clear",  int'(bus.done),        0);
        chk("avl0_ready_back",  int'(bus.cfg_ready),   1);
        wait_idle();

        // Illegal SEW, then illegal LMUL.
        for (int t = 0; t < 2; t++) begin
            push_evt(K_ERR);
            if (t == 0) send_cfg(24, 1, 10);
            else        send_cfg(8, 3, 10);
            @(negedge clk);
            chk("err_pulse",      int'(bus.cfg_err),     1);
            chk("err_no_strip",   int'(bus.strip_valid), 0);
            chk("err_no_done",    int'(bus.done),        0);
            @(negedge clk);
            chk("err_pulse_1cyc", int'(bus.cfg_err),     0);
            chk("err_ready_back", int'(bus.cfg_ready),   1);
            wait_idle();
        end

        // SEW64 LMUL1: vlmax 2, AVL 5, stall 3 cycles with a stray cfg in RUN.
        bus.strip_ready = 1'b0;
        push_strip(2, 0, 0, 0);
        push_strip(2, 2, 1, 0);
        push_strip(1, 4, 2, 1);
        push_evt(K_DONE);
        send_cfg(64, 1, 5);
        bus.cfg_sew   = 8'd8;
        bus.cfg_lmul  = 5'd16;
        bus.cfg_avl   = 9'd100;
        bus.cfg_valid = 1'b1;
        repeat (3) step();
        bus.cfg_valid   = 1'b0;
        bus.strip_ready = 1'b1;
        wait_idle();

        // Abort after the idx1 handshake while idx2 is stalled.
        push_strip(8, 0, 0, 0);
        push_strip(8, 8, 1, 0);
        send_cfg(16, 1, 40);
        step();
        step();
        bus.strip_ready = 1'b0;
        bus.abort       = 1'b1;
        step();
        bus.abort = 1'b0;
        @(negedge clk);
        chk("abort_valid_low", int'(bus.strip_valid), 0);
        chk("abort_no_done",   int'(bus.done),        0);
        chk("abort_ready",     int'(bus.cfg_ready),   1);
        repeat (3) step();
        chk("abort_sb_empty", sb.size(), 0);

        // Abort held through IDLE is ignored; abort on the last handshake kills done.
        bus.strip_ready = 1'b1;
        bus.abort       = 1'b1;
        push_strip(2, 0, 0, 1);
        send_cfg(64, 1, 2);
        step();
        bus.abort = 1'b0;
        @(negedge clk);
        chk("abort_hs_no_done", int'(bus.done),      0);
        chk("abort_hs_ready",   int'(bus.cfg_ready), 1);
        repeat (3) step();
        chk("abort_hs_sb_empty", sb.size(), 0);

        // Synchronous reset in the middle of a run.
        push_strip(8, 0, 0, 0);
        send_cfg(16, 1, 40);
        step();
        bus.strip_ready = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("mrst_cfg_ready",   int'(bus.cfg_ready),   1);
        chk("mrst_strip_valid", int'(bus.strip_valid), 0);
        chk("mrst_strip_vl",    int'(bus.strip_vl),    0);
        chk("mrst_strip_off",   int'(bus.strip_off),   0);
        chk("mrst_strip_idx",   int'(bus.strip_idx),   0);
        chk("mrst_done",        int'(bus.done),        0);
        repeat (3) step();

        chk("scoreboard_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
